// File: rtl/keccak_pad_packer.sv
// keccak_pad_packer: packs message words into Keccak rate blocks and applies SHA3/SHAKE padding.
// Latency: block_valid_o rises one cycle after the word that completes a block is accepted.
// Backpressure: block_ready_i stalls the output block. While it is stalled, din_ready_o stays low (single
//               buffer) or stays low only once the fill buffer is also complete (double buffer).
//               hold_i freezes everything.
// Build option: define KECCAK_PACKER_DBUF_EN to add a second 1344-bit fill buffer, so absorption
//               overlaps with output stalls.
// Ports: clk_i/rst_i clock and synchronous active-high reset; mode_i/start_i begin a message;
//        din_i/din_valid_i/din_ready_o word handshake with last_din_i/last_din_byte_i marking the tail;
//        hold_i global freeze; block_o/block_valid_o/block_ready_i/block_last_o rate-block output;
//        busy_o (not idle) and err_o (one-cycle pulse for an illegal mode or an oversized byte count).
module keccak_pad_packer #(
    parameter  int DIN_W = 64,
    localparam int BW    = $clog2(DIN_W/8) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       mode_i,
    input  logic             start_i,
    input  logic [DIN_W-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    input  logic             last_din_i,
    input  logic [BW-1:0]    last_din_byte_i,
    input  logic             hold_i,
    output logic [1343:0]    block_o,
    output logic             block_valid_o,
    input  logic             block_ready_i,
    output logic             block_last_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int WB    = DIN_W / 8;
    localparam int LG_WB = $clog2(WB);
    localparam int LG_DW = $clog2(DIN_W);
    localparam int BLK_W = 1344;

    typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_PADBLK, S_EMIT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_mode;
    logic [5:0]  r_wcnt;
    logic        r_err;

    logic [7:0]  w_rate;
    logic [7:0]  w_dbyte;
    logic [7:0]  w_wpb;
    logic        w_mode_ok;
    logic        w_start;
    logic        w_n_big;
    logic [BW-1:0] w_n;
    logic        w_acc;
    logic        w_last_acc;
    logic        w_blk_end;
    logic        w_exact_pos;
    logic        w_exact;
    logic        w_blk_done;
    logic [DIN_W-1:0] w_word;
    logic [10:0] w_word_sh;
    logic [10:0] w_d_sh;
    logic [10:0] w_end_sh;
    logic [BLK_W-1:0] w_data_vec;
    logic [BLK_W-1:0] w_dom_vec;
    logic [BLK_W-1:0] w_end_vec;
    logic [BLK_W-1:0] w_ins;
    logic [BLK_W-1:0] w_pad_blk;

    // Rate in bytes and domain-separation byte of the latched mode.
    always_comb begin
        w_rate  = 8'd136;
        w_dbyte = 8'h06;
        case (r_mode)
            3'b001: w_rate = 8'd72;
            3'b010: w_dbyte = 8'h1F;
            3'b011: begin
                w_rate  = 8'd168;
                w_dbyte = 8'h1F;
            end
            3'b100: w_rate = 8'd104;
            default: ;
        endcase
    end

    assign w_wpb     = w_rate >> LG_WB;
    assign w_mode_ok = (mode_i <= 3'b100);
    assign w_start   = (r_state == S_IDLE) && start_i && w_mode_ok;

    assign w_n_big = (last_din_byte_i > BW'(WB));
    assign w_n     = w_n_big ? BW'(WB) : last_din_byte_i;

    assign w_acc       = din_valid_i && din_ready_o;
    assign w_last_acc  = w_acc && last_din_i;
    assign w_blk_end   = ({2'b00, r_wcnt} == (w_wpb - 8'd1));
    // A full last word in the final slot leaves no room for the domain byte, so a separate pad block follows.
    assign w_exact_pos = (w_n == BW'(WB)) && w_blk_end;
    assign w_exact     = w_last_acc && w_exact_pos;
    assign w_blk_done  = w_acc && (last_din_i || w_blk_end);

    // Zero the bytes past the valid count of the final word.
    always_comb begin
        w_word = din_i;
        if (last_din_i) begin
            for (int b = 0; b < WB; b++) begin
                if (BW'(b) >= w_n) w_word[8*b +: 8] = 8'h00;
            end
        end
    end

    assign w_word_sh = 11'(r_wcnt) << LG_DW;
    assign w_d_sh    = w_word_sh + (11'(w_n) << 3);
    assign w_end_sh  = (11'(w_rate) - 11'd1) << 3;

    assign w_data_vec = {{(BLK_W-DIN_W){1'b0}}, w_word} << w_word_sh;
    assign w_dom_vec  = {{(BLK_W-8){1'b0}}, w_dbyte} << w_d_sh;
    assign w_end_vec  = {{(BLK_W-8){1'b0}}, 8'h80} << w_end_sh;
    // The domain byte and 0x80 are XORed together so that they merge when both land on byte R-1.
    assign w_ins      = w_data_vec | ((last_din_i && !w_exact_pos) ? (w_dom_vec ^ w_end_vec) : '0);
    assign w_pad_blk  = {{(BLK_W-8){1'b0}}, w_dbyte} ^ w_end_vec;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Recomputed every cycle so the pulse is exactly one cycle long, even when a hold starts right after it.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_err <= 1'b0;
        else       r_err <= !hold_i && (((r_state == S_IDLE) && start_i && !w_mode_ok) ||
                                        (w_last_acc && w_n_big));
    end

    assign err_o  = r_err;
    assign busy_o = (r_state != S_IDLE);

`ifdef KECCAK_PACKER_DBUF_EN
    logic [BLK_W-1:0] r_fill;
    logic [BLK_W-1:0] r_out;
    logic             r_fill_full;
    logic             r_fill_last;
    logic             r_out_vld;
    logic             r_out_last;
    logic [BLK_W-1:0] w_fill_base;
    logic [BLK_W-1:0] w_new_fill;
    logic [BLK_W-1:0] w_cmp_blk;
    logic             w_fire;
    logic             w_out_free;
    logic             w_handover;
    logic             w_pad_go;
    logic             w_cmp;
    logic             w_cmp_last;
    logic             w_direct;

    assign w_fire      = r_out_vld && block_ready_i && !hold_i;
    assign w_out_free  = !r_out_vld || w_fire;
    assign w_handover  = !hold_i && r_fill_full && w_out_free;
    assign w_pad_go    = !hold_i && (r_state == S_PADBLK) && !r_fill_full;
    // A word accepted during a hand-over starts a fresh block in the buffer being vacated.
    assign w_fill_base = r_fill_full ? '0 : r_fill;
    assign w_new_fill  = w_fill_base | w_ins;
    assign w_cmp       = w_blk_done || w_pad_go;
    assign w_cmp_blk   = w_pad_go ? w_pad_blk : w_new_fill;
    assign w_cmp_last  = w_pad_go || (last_din_i && !w_exact_pos);
    // A completed block goes straight to the output register when that register is free.
    assign w_direct    = w_cmp && w_out_free && !r_fill_full;

    always_comb begin
        w_state_nxt = r_state;
        if (!hold_i) begin
            case (r_state)
                S_IDLE:   if (start_i && w_mode_ok) w_state_nxt = S_ABSORB;
                S_ABSORB: if (w_last_acc) w_state_nxt = w_exact ? S_PADBLK : S_EMIT;
                S_PADBLK: if (w_pad_go) w_state_nxt = S_EMIT;
                S_EMIT:   if (w_fire && r_out_last) w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        din_ready_o   = (r_state == S_ABSORB) && !hold_i && !(r_fill_full && r_out_vld);
        block_valid_o = r_out_vld;
        block_last_o  = r_out_last;
        block_o       = r_out;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode      <= 3'b000;
            r_wcnt      <= 6'd0;
            r_fill      <= '0;
            r_fill_full <= 1'b0;
            r_fill_last <= 1'b0;
            r_out       <= '0;
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (!hold_i) begin
            if (w_start) begin
                r_mode      <= mode_i;
                r_wcnt      <= 6'd0;
                r_fill      <= '0;
                r_fill_full <= 1'b0;
                r_fill_last <= 1'b0;
            end else if (w_cmp) begin
                r_wcnt <= 6'd0;
                if (w_direct) begin
                    r_fill <= '0;
                end else begin
                    r_fill      <= w_cmp_blk;
                    r_fill_full <= 1'b1;
                    r_fill_last <= w_cmp_last;
                end
            end else if (w_acc) begin
                r_fill      <= w_new_fill;
                r_wcnt      <= r_wcnt + 6'd1;
                r_fill_full <= 1'b0;
            end else if (w_handover) begin
                r_fill      <= '0;
                r_fill_full <= 1'b0;
            end

            if (w_handover) begin
                r_out      <= r_fill;
                r_out_vld  <= 1'b1;
                r_out_last <= r_fill_last;
            end else if (w_direct) begin
                r_out      <= w_cmp_blk;
                r_out_vld  <= 1'b1;
                r_out_last <= w_cmp_last;
            end else if (w_fire) begin
                r_out      <= '0;
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
            end
        end
    end
`else
    logic [BLK_W-1:0] r_buf;
    logic             r_last;
    logic             r_pad_pend;
    logic             w_fire;

    assign w_fire = (r_state == S_EMIT) && block_ready_i && !hold_i;

    always_comb begin
        w_state_nxt = r_state;
        if (!hold_i) begin
            case (r_state)
                S_IDLE:   if (start_i && w_mode_ok) w_state_nxt = S_ABSORB;
                S_ABSORB: if (w_blk_done) w_state_nxt = S_EMIT;
                S_PADBLK: w_state_nxt = S_EMIT;
                S_EMIT: begin
                    if (w_fire) begin
                        if (r_last)          w_state_nxt = S_IDLE;
                        else if (r_pad_pend) w_state_nxt = S_PADBLK;
                        else                 w_state_nxt = S_ABSORB;
                    end
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        din_ready_o   = (r_state == S_ABSORB) && !hold_i;
        block_valid_o = (r_state == S_EMIT);
        block_last_o  = (r_state == S_EMIT) && r_last;
        block_o       = r_buf;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode     <= 3'b000;
            r_wcnt     <= 6'd0;
            r_buf      <= '0;
            r_last     <= 1'b0;
            r_pad_pend <= 1'b0;
        end else if (!hold_i) begin
            if (w_start) begin
                r_mode     <= mode_i;
                r_wcnt     <= 6'd0;
                r_buf      <= '0;
                r_last     <= 1'b0;
                r_pad_pend <= 1'b0;
            end else if (w_acc) begin
                r_buf  <= r_buf | w_ins;
                r_wcnt <= r_wcnt + 6'd1;
                if (w_blk_done) begin
                    r_last     <= last_din_i && !w_exact_pos;
                    r_pad_pend <= w_exact;
                end
            end else if (r_state == S_PADBLK) begin
                r_buf      <= w_pad_blk;
                r_last     <= 1'b1;
                r_pad_pend <= 1'b0;
            end else if (w_fire) begin
                r_buf  <= '0;
                r_wcnt <= 6'd0;
                r_last <= 1'b0;
            end
        end
    end
`endif

endmodule
